// File: rtl/pi1_pkg.sv
// Shared pi1 bus definitions: op codes, arbitration modes, FSM states and clog2.
package pi1_pkg;

  localparam logic [1:0] PINOOP = 2'd0;
  localparam logic [1:0] PIWROP = 2'd1;
  localparam logic [1:0] PIRDOP = 2'd2;
  localparam logic [1:0] PIRWOP = 2'd3;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pi1_rrpick.sv
// Rotating-priority encoder: first requester at or above ptr wins, else lowest requester.
// Purely combinational; vld is high whenever any request is present.
module pi1_rrpick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          vld
);

  logic [N-1:0] upper;
  logic [N-1:0] cand;

  always_comb begin
    upper = {N{1'b1}} << ptr;
    cand  = ((req & upper) != '0) ? (req & upper) : req;
    // isolate lowest set bit of the candidate set
    win   = cand & (~cand + N'(1));
    vld   = (req != '0);
  end

endmodule

// File: rtl/pi1_arb.sv
// pi1 bus arbiter: N masters onto one slave, fixed or round-robin, back-to-back grants.
// Grant is registered; request/response paths are combinational through the granted master.
module pi1_arb
  import pi1_pkg::*;
#(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 32,
  parameter int ARBMODE     = 1,
  localparam int ADDRBITSZ  = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  localparam int SELBITSZ   = ARCHBITSZ / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [2*MASTERCOUNT-1:0]         m_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
  input  logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i,
  output logic [ARCHBITSZ-1:0]             m_data_o,
  output logic [MASTERCOUNT-1:0]           m_rdy_o,
  output logic [1:0]                       s_op_o,
  output logic [ADDRBITSZ-1:0]             s_addr_o,
  output logic [ARCHBITSZ-1:0]             s_data_o,
  output logic [SELBITSZ-1:0]              s_sel_o,
  input  logic [ARCHBITSZ-1:0]             s_data_i,
  input  logic                             s_rdy_i,
  output logic [MASTERCOUNT-1:0]           gnt_o
);

  localparam int PW = (MASTERCOUNT > 1) ? clog2(MASTERCOUNT) : 1;

  arb_state_t             state;
  logic [MASTERCOUNT-1:0] g;
  logic [PW-1:0]          p;
  logic [PW-1:0]          p_nxt;
  logic [PW-1:0]          gidx;
  logic [MASTERCOUNT-1:0] req;
  logic [MASTERCOUNT-1:0] win;
  logic                   win_vld;
  logic                   busy;
  logic                   done;
  logic                   abort;
  logic                   rearb;

  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      req[i] = (m_op_i[2*i +: 2] != PINOOP);
    end
  end

  // g is all-zero in IDLE, so the AND-OR mux naturally drives zeros then
  always_comb begin
    s_op_o   = PINOOP;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    gidx     = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      if (g[i]) begin
        s_op_o   = m_op_i[2*i +: 2];
        s_addr_o = m_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
        s_data_o = m_data_i[ARCHBITSZ*i +: ARCHBITSZ];
        s_sel_o  = m_sel_i[SELBITSZ*i +: SELBITSZ];
        gidx     = PW'(i);
      end
    end
  end

  assign busy     = (state == ST_BUSY);
  assign done     = busy && (s_op_o != PINOOP) && s_rdy_i;
  assign abort    = busy && (s_op_o == PINOOP);
  assign rearb    = !busy || done || abort;
  assign m_rdy_o  = g & {MASTERCOUNT{done}};
  assign m_data_o = busy ? s_data_i : '0;
  assign gnt_o    = g;

  // pointer only advances on a real completion; aborts leave it alone
  always_comb begin
    p_nxt = p;
    if (ARBMODE == ARB_RR && MASTERCOUNT > 1 && done) begin
      if (gidx == PW'(MASTERCOUNT - 1)) p_nxt = '0;
      else                              p_nxt = gidx + 1'b1;
    end
  end

  pi1_rrpick #(
    .N  (MASTERCOUNT),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (p_nxt),
    .win (win),
    .vld (win_vld)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
      g     <= '0;
      p     <= '0;
    end else if (rearb) begin
      p <= p_nxt;
      if (win_vld) begin
        g     <= win;
        state <= ST_BUSY;
      end else begin
        g     <= '0;
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_pi1_arb.sv
// Bench: round-robin and fixed-priority arbiters side by side against a queue-free index model.
module tb_pi1_arb;

  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic [1:0]    op   [N];
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdat [N];
  logic [SW-1:0] sel  [N];
  logic [DW-1:0] s_data;
  logic          s_rdy;

  logic [2*N-1:0]  m_op;
  logic [AW*N-1:0] m_addr;
  logic [DW*N-1:0] m_data;
  logic [SW*N-1:0] m_sel;

  always_comb begin
    m_op = '0; m_addr = '0; m_data = '0; m_sel = '0;
    for (int i = 0; i < N; i++) begin
      m_op[2*i +: 2]    = op[i];
      m_addr[AW*i +: AW] = addr[i];
      m_data[DW*i +: DW] = wdat[i];
      m_sel[SW*i +: SW]  = sel[i];
    end
  end

  logic [DW-1:0] m_data_w [2];
  logic [N-1:0]  m_rdy_w  [2];
  logic [1:0]    s_op_w   [2];
  logic [AW-1:0] s_addr_w [2];
  logic [DW-1:0] s_data_w [2];
  logic [SW-1:0] s_sel_w  [2];
  logic [N-1:0]  gnt_w    [2];

  pi1_arb #(.MASTERCOUNT(N), .ARCHBITSZ(DW), .ARBMODE(1)) u_rr (
    .clk_i(clk), .rst_i(rst_i),
    .m_op_i(m_op), .m_addr_i(m_addr), .m_data_i(m_data), .m_sel_i(m_sel),
    .m_data_o(m_data_w[0]), .m_rdy_o(m_rdy_w[0]),
    .s_op_o(s_op_w[0]), .s_addr_o(s_addr_w[0]), .s_data_o(s_data_w[0]), .s_sel_o(s_sel_w[0]),
    .s_data_i(s_data), .s_rdy_i(s_rdy), .gnt_o(gnt_w[0])
  );

  pi1_arb #(.MASTERCOUNT(N), .ARCHBITSZ(DW), .ARBMODE(0)) u_fx (
    .clk_i(clk), .rst_i(rst_i),
    .m_op_i(m_op), .m_addr_i(m_addr), .m_data_i(m_data), .m_sel_i(m_sel),
    .m_data_o(m_data_w[1]), .m_rdy_o(m_rdy_w[1]),
    .s_op_o(s_op_w[1]), .s_addr_o(s_addr_w[1]), .s_data_o(s_data_w[1]), .s_sel_o(s_sel_w[1]),
    .s_data_i(s_data), .s_rdy_i(s_rdy), .gnt_o(gnt_w[1])
  );

  // model: owner = granted master index (-1 when idle), ptr = search start
  int owner [2];
  int ptr   [2];
  int mode  [2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      ptr[k]   = 0;
    end
  endtask

  // one clock: compare at negedge, compute next model state, commit after posedge
  task automatic step();
    int nown [2];
    int nptr [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int o;
      int np;
      logic fin;
      logic [63:0] one;
      o = owner[k];
      nown[k] = o;
      nptr[k] = ptr[k];
      if (o >= 0) begin
        one = 64'd1 << o;
        fin = (op[o] != 2'd0) && s_rdy;
        chk($sformatf("gnt%0d", k),    gnt_w[k],    one);
        chk($sformatf("s_op%0d", k),   s_op_w[k],   op[o]);
        chk($sformatf("s_addr%0d", k), s_addr_w[k], addr[o]);
        chk($sformatf("s_data%0d", k), s_data_w[k], wdat[o]);
        chk($sformatf("s_sel%0d", k),  s_sel_w[k],  sel[o]);
        chk($sformatf("m_rdy%0d", k),  m_rdy_w[k],  fin ? one : 64'd0);
        chk($sformatf("m_data%0d", k), m_data_w[k], s_data);
      end else begin
        fin = 1'b0;
        chk($sformatf("idle_gnt%0d", k),    gnt_w[k],    0);
        chk($sformatf("idle_s_op%0d", k),   s_op_w[k],   0);
        chk($sformatf("idle_s_addr%0d", k), s_addr_w[k], 0);
        chk($sformatf("idle_m_rdy%0d", k),  m_rdy_w[k],  0);
        chk($sformatf("idle_m_data%0d", k), m_data_w[k], 0);
      end
      if (o < 0 || op[o] == 2'd0 || s_rdy) begin
        np = ptr[k];
        if (fin && mode[k] == 1) np = (o + 1) % N;
        nown[k] = -1;
        for (int j = 0; j < N; j++) begin
          if (nown[k] < 0 && op[(np + j) % N] != 2'd0) nown[k] = (np + j) % N;
        end
        nptr[k] = np;
      end
    end
    @(posedge clk);
    #1;
    if (rst_i) begin
      for (int k = 0; k < 2; k++) begin
        owner[k] = nown[k];
        ptr[k]   = nptr[k];
      end
    end
  endtask

  // reset asserted between edges must clear outputs without a clock
  task automatic areset();
    #2;
    rst_i = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_gnt%0d", k),    gnt_w[k],    0);
      chk($sformatf("arst_s_op%0d", k),   s_op_w[k],   0);
      chk($sformatf("arst_m_rdy%0d", k),  m_rdy_w[k],  0);
      chk($sformatf("arst_m_data%0d", k), m_data_w[k], 0);
    end
    model_reset();
    step();
    rst_i = 1'b1;
  endtask

  logic [N-1:0] seq_rr [5];

  initial begin
    mode[0] = 1;
    mode[1] = 0;
    model_reset();
    seq_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_i  = 1'b0;
    s_rdy  = 1'b1;
    s_data = 32'h1234_5678;
    for (int i = 0; i < N; i++) begin
      op[i]   = 2'd2;
      addr[i] = AW'(32'h100 + i);
      wdat[i] = 32'hA000_0000 + i;
      sel[i]  = 4'hF;
    end

    // held in reset with every master requesting
    step();
    step();
    rst_i = 1'b1;

    // all masters reading continuously, slave always ready
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq", gnt_w[0], seq_rr[i]);
      chk("fx_seq", gnt_w[1], 4'b0001);
    end

    // fixed priority: master 1 keeps the bus while it requests
    op = '{2'd0, 2'd2, 2'd0, 2'd2};
    step();
    step();
    chk("fx_hold", gnt_w[1], 4'b0010);
    step();
    chk("fx_hold2", gnt_w[1], 4'b0010);
    op[1] = 2'd0;
    step();
    chk("fx_next", gnt_w[1], 4'b1000);

    // slave stalls a read from master 2
    op = '{2'd0, 2'd0, 2'd0, 2'd0};
    step();
    op[2]   = 2'd2;
    addr[2] = AW'(32'h40);
    s_rdy   = 1'b0;
    step();
    chk("stall_gnt", gnt_w[0], 4'b0100);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rdy", m_rdy_w[0], 0);
      chk("stall_addr", s_addr_w[0], 32'h40);
    end
    s_rdy  = 1'b1;
    s_data = 32'hDEAD_BEEF;
    #1;
    chk("cmpl_rdy", m_rdy_w[0], 4'b0100);
    chk("cmpl_data", m_data_w[0], 32'hDEAD_BEEF);
    chk("cmpl_addr", s_addr_w[0], 32'h40);
    step();

    // master 0 write granted then withdrawn before the slave answers
    op[2] = 2'd0;
    op[0] = 2'd1;
    s_rdy = 1'b0;
    step();
    chk("abort_gnt", gnt_w[0], 4'b0001);
    op[0] = 2'd0;
    op[1] = 2'd2;
    op[3] = 2'd2;
    s_rdy = 1'b1;
    #1;
    chk("abort_rdy_rr", m_rdy_w[0], 0);
    chk("abort_rdy_fx", m_rdy_w[1], 0);
    step();
    chk("abort_ptr_rr", gnt_w[0], 4'b1000);
    chk("abort_ptr_fx", gnt_w[1], 4'b0010);

    // asynchronous reset in the middle of a stalled transfer
    s_rdy = 1'b0;
    areset();
    step();
    chk("rst_first_rr", gnt_w[0], 4'b0010);
    chk("rst_first_fx", gnt_w[1], 4'b0010);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          op[i]   = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
          addr[i] = AW'($urandom);
          wdat[i] = $urandom;
          sel[i]  = SW'($urandom);
        end
      end
      s_rdy  = ($urandom_range(0, 2) != 0);
      s_data = $urandom;
      if (c % 97 == 50) areset();
      else              step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
